// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response port of the fetch unit.
// The fetch unit is the master; the memory is the slave.
interface fetch_pc_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage of the 5-stage core: owns the PC, keeps one imem request in
// flight and presents inst_if/pc_if/pc_plus_4_if to the IF/ID register.
module fetch_pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    fetch_pc_unit_if.master  imem,
    output logic [WIDTH-1:0] inst_if,
    output logic [WIDTH-1:0] pc_if,
    output logic [WIDTH-1:0] pc_plus_4_if,
    output logic             fetch_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             drop_q, drop_d;
    logic             fv_d;
    logic [WIDTH-1:0] inst_d;
    logic [WIDTH-1:0] pcif_d;
    logic [WIDTH-1:0] pcp4_d;
    logic [WIDTH-1:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};

    assign imem.imem_req_valid = (state_q == S_REQ);
    assign imem.imem_req_addr  = (state_q == S_REQ) ? pc_q : '0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        fv_d    = fetch_valid;
        inst_d  = inst_if;
        pcif_d  = pc_if;
        pcp4_d  = pc_plus_4_if;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // A redirect on the accepting cycle leaves a stale response in flight.
                if (imem.imem_req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                        fv_d    = 1'b1;
                        inst_d  = imem.imem_rsp_data;
                        pcif_d  = pc_q;
                        pcp4_d  = pc_q + WIDTH'(4);
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || !stall_if) begin
                    state_d = S_REQ;
                    fv_d    = 1'b0;
                    inst_d  = '0;
                    if (!redirect_valid) begin
                        pc_d = pc_q + WIDTH'(4);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect outranks stall and every state-specific PC update.
        if (redirect_valid) begin
            pc_d   = redirect_aligned;
            fv_d   = 1'b0;
            inst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            fetch_valid  <= 1'b0;
            inst_if      <= '0;
            pc_if        <= '0;
            pc_plus_4_if <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            fetch_valid  <= fv_d;
            inst_if      <= inst_d;
            pc_if        <= pcif_d;
            pc_plus_4_if <= pcp4_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit: per-cycle input/expected-output
// table followed by an asynchronous-reset sequence.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_if;
    logic [31:0] pc_if;
    logic [31:0] pc_plus_4_if;
    logic        fetch_valid;

    fetch_pc_unit_if #(.WIDTH(32)) imem_if ();

    fetch_pc_unit #(
        .WIDTH   (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem          (imem_if.master),
        .inst_if       (inst_if),
        .pc_if         (pc_if),
        .pc_plus_4_if  (pc_plus_4_if),
        .fetch_valid   (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ready;
        logic        rsp;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_fail;

    task automatic add(input logic stall, input logic rv, input logic [31:0] rpc,
                       input logic ready, input logic rsp, input logic [31:0] data,
                       input logic e_req, input logic [31:0] e_addr, input logic e_fv,
                       input logic [31:0] e_inst, input logic [31:0] e_pc,
                       input logic [31:0] e_p4);
        vec_t v;
        v.stall = stall; v.rv = rv; v.rpc = rpc; v.ready = ready; v.rsp = rsp;
        v.data = data; v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_p4 = e_p4;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_fv, input logic [31:0] e_inst,
                           input logic [31:0] e_pc, input logic [31:0] e_p4);
        chk({tag, " req_valid"}, {31'd0, imem_if.imem_req_valid}, {31'd0, e_req});
        chk({tag, " req_addr"},  imem_if.imem_req_addr, e_addr);
        chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
        chk({tag, " inst_if"}, inst_if, e_inst);
        chk({tag, " pc_if"}, pc_if, e_pc);
        chk({tag, " pc_plus_4_if"}, pc_plus_4_if, e_p4);
    endtask

    task automatic drive(input logic stall, input logic rv, input logic [31:0] rpc,
                         input logic ready, input logic rsp, input logic [31:0] data);
        stall_if                = stall;
        redirect_valid          = rv;
        redirect_pc             = rpc;
        imem_if.imem_req_ready  = ready;
        imem_if.imem_rsp_valid  = rsp;
        imem_if.imem_rsp_data   = data;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        //  stall rv rpc           rdy rsp data         | req addr          fv inst          pc_if         p4
        // first fetch
        add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,         0, 32'h0,        32'h0,        32'h0);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        32'h0);
        add(0, 0, 32'h0,          0, 1, 32'h00500093,   0, 32'h0,         1, 32'h00500093, 32'h0,        32'h4);
        // stall three cycles in HOLD, then advance to PC 4
        add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'h00500093, 32'h0,        32'h4);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'h00500093, 32'h0,        32'h4);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'h00500093, 32'h0,        32'h4);
        add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,         0, 32'h0,        32'h0,        32'h4);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        32'h4);
        // redirect while waiting: stale response dropped
        add(0, 1, 32'h102,        0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        32'h4);
        add(0, 0, 32'h0,          0, 1, 32'hDEADBEEF,   1, 32'h100,       0, 32'h0,        32'h0,        32'h4);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0,        32'h4);
        add(0, 0, 32'h0,          0, 1, 32'h00A00113,   0, 32'h0,         1, 32'h00A00113, 32'h100,      32'h104);
        // redirect and stall together in HOLD
        add(1, 1, 32'h200,        0, 0, 32'h0,          1, 32'h200,       0, 32'h0,        32'h100,      32'h104);
        // redirect on the accepting cycle, then wrap fetch
        add(0, 1, 32'hFFFFFFFF,   1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h100,      32'h104);
        add(0, 0, 32'h0,          0, 1, 32'h11111111,   1, 32'hFFFFFFFC,  0, 32'h0,        32'h100,      32'h104);
        add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFFFFFC,  0, 32'h0,        32'h100,      32'h104);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h100,      32'h104);
        add(0, 0, 32'h0,          0, 1, 32'h00000013,   0, 32'h0,         1, 32'h00000013, 32'hFFFFFFFC, 32'h0);
        add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,         0, 32'h0,        32'hFFFFFFFC, 32'h0);
        // redirect in REQ not accepted
        add(0, 1, 32'h40,         0, 0, 32'h0,          1, 32'h40,        0, 32'h0,        32'hFFFFFFFC, 32'h0);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'hFFFFFFFC, 32'h0);
        // redirect with the response on the same cycle
        add(0, 1, 32'h80,         0, 1, 32'h22222222,   1, 32'h80,        0, 32'h0,        32'hFFFFFFFC, 32'h0);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'hFFFFFFFC, 32'h0);
        add(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'hFFFFFFFC, 32'h0);
        add(0, 0, 32'h0,          0, 1, 32'h33333333,   0, 32'h0,         1, 32'h33333333, 32'h80,       32'h84);
        // stray responses outside WAIT are ignored
        add(0, 0, 32'h0,          0, 1, 32'h44444444,   1, 32'h84,        0, 32'h0,        32'h80,       32'h84);
        add(0, 0, 32'h0,          0, 1, 32'h55555555,   1, 32'h84,        0, 32'h0,        32'h80,       32'h84);
        add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h80,       32'h84);

        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ready, vecs[i].rsp, vecs[i].data);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_fv,
                    vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_p4);
        end

        // asynchronous reset while a request is outstanding
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 1, 32'h66666666);
        @(posedge clk);
        #1;
        chk_all("post_rst_stray", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("post_rst_req", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
